// File: rtl/decod_pipe.sv
// decod_pipe: RV32-style instruction decoder feeding a small FIFO of decoded
// entries, with a register scoreboard that holds the head entry until its
// source registers have been written back.
// Optional feature: define DECOD_PIPE_IMM_EN to decode and store immediates;
// without it imm is constant 0 and no immediate storage exists.
module decod_pipe #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  inst,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic [6:0]   opcode,
  output logic [2:0]   func3,
  output logic [6:0]   func7,
  output logic         f_en,
  output logic         rd_we,
  output logic [W-1:0] imm,
  output logic         illegal,
  input  logic         wb_valid,
  input  logic [4:0]   wb_rd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Stored per-entry flags: {illegal, rd_we, uses_rs1, uses_rs2}
  localparam int unsigned FL_ILL = 3;
  localparam int unsigned FL_WE  = 2;
  localparam int unsigned FL_U1  = 1;
  localparam int unsigned FL_U2  = 0;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pending_q, pending_d;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [3:0]    flag_mem_q [DEPTH];

  logic          empty, full, push, pop, hazard;
  logic [AW-1:0] head_idx;
  logic [31:0]   hd_inst;
  logic [3:0]    hd_flags;
  logic [3:0]    dec_flags;

  assign head_idx = rd_ptr_q[AW-1:0];
  assign hd_inst  = inst_mem_q[head_idx];
  assign hd_flags = flag_mem_q[head_idx];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push = in_valid && !full && !flush;
  assign pop  = out_valid && out_ready;

  // Decode class flags of the incoming word at accept time
  always_comb begin
    dec_flags = 4'b0000;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: dec_flags[FL_WE] = 1'b1;
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        dec_flags[FL_WE] = 1'b1;
        dec_flags[FL_U1] = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        dec_flags[FL_U1] = 1'b1;
        dec_flags[FL_U2] = 1'b1;
      end
      OP_OP: begin
        dec_flags[FL_WE] = 1'b1;
        dec_flags[FL_U1] = 1'b1;
        dec_flags[FL_U2] = 1'b1;
      end
      OP_SYSTEM: dec_flags = 4'b0000;
      default:   dec_flags[FL_ILL] = 1'b1;
    endcase
    // Writes to x0 are discarded, so they never mark the scoreboard
    if (inst[11:7] == 5'd0) dec_flags[FL_WE] = 1'b0;
  end

`ifdef DECOD_PIPE_IMM_EN
  logic [31:0]  imm32;
  logic [W-1:0] imm_mem_q [DEPTH];

  // Immediate format selection by opcode, 32-bit before widening
  always_comb begin
    imm32 = 32'd0;
    case (inst[6:0])
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst[31:12], 12'd0};
      OP_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
  end

  // Immediate storage, written on accept
  always_ff @(posedge clk) begin
    if (push) imm_mem_q[wr_ptr_q[AW-1:0]] <= W'($signed(imm32));
  end
`endif

  // Entry storage, written on accept; contents are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q[AW-1:0]] <= inst;
      flag_mem_q[wr_ptr_q[AW-1:0]] <= dec_flags;
    end
  end

  // Pointer next-state: flush overrides any same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Scoreboard next-state: a set from a pop wins over a same-register clear
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (pop && hd_flags[FL_WE]) pending_d[hd_inst[11:7]] = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Head hazard check against registered pending bits; x0 never stalls
  always_comb begin
    hazard = 1'b0;
    if (hd_flags[FL_U1] && (hd_inst[19:15] != 5'd0) && pending_q[hd_inst[19:15]])
      hazard = 1'b1;
    if (hd_flags[FL_U2] && (hd_inst[24:20] != 5'd0) && pending_q[hd_inst[24:20]])
      hazard = 1'b1;
  end

  // Output fields from the head entry, zero while the FIFO is empty
  always_comb begin
    in_ready  = !full;
    out_valid = !empty && !hazard;
    rs1       = empty ? 5'd0 : hd_inst[19:15];
    rs2       = empty ? 5'd0 : hd_inst[24:20];
    rd        = empty ? 5'd0 : hd_inst[11:7];
    opcode    = empty ? 7'd0 : hd_inst[6:0];
    func3     = empty ? 3'd0 : hd_inst[14:12];
    func7     = empty ? 7'd0 : hd_inst[31:25];
    f_en      = empty ? 1'b0 : hd_inst[28];
    rd_we     = empty ? 1'b0 : hd_flags[FL_WE];
    illegal   = empty ? 1'b0 : hd_flags[FL_ILL];
`ifdef DECOD_PIPE_IMM_EN
    imm       = empty ? '0 : imm_mem_q[head_idx];
`else
    imm       = '0;
`endif
  end

endmodule

// File: tb/tb_decod_pipe.sv
// Testbench for decod_pipe: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based reference model.
module tb_decod_pipe;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]  inst;
  logic [4:0]   rs1, rs2, rd, wb_rd;
  logic [6:0]   opcode, func7;
  logic [2:0]   func3;
  logic         f_en, rd_we, illegal, wb_valid;
  logic [W-1:0] imm;

  decod_pipe #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .func3(func3), .func7(func7),
    .f_en(f_en), .rd_we(rd_we), .imm(imm), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queued raw words plus the set of pending registers
  logic [31:0] mq[$];
  logic [31:0] pend;

  logic [6:0] opl [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011, 7'b1110011};

  function automatic bit m_legal(input logic [31:0] w);
    return w[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011, 7'b1110011};
  endfunction

  function automatic bit m_we(input logic [31:0] w);
    return (w[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                           7'b0010011, 7'b0110011}) && (w[11:7] != 5'd0);
  endfunction

  function automatic bit m_u1(input logic [31:0] w);
    return w[6:0] inside {7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic bit m_u2(input logic [31:0] w);
    return w[6:0] inside {7'b0100011, 7'b1100011, 7'b0110011};
  endfunction

  function automatic logic [W-1:0] m_imm(input logic [31:0] w);
    longint v;
    v = 0;
`ifdef DECOD_PIPE_IMM_EN
    case (w[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: v = $signed(w[31:20]);
      7'b0100011: v = $signed({w[31:25], w[11:7]});
      7'b1100011: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      7'b0110111, 7'b0010111: v = $signed({w[31:12], 12'h000});
      7'b1101111: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: v = 0;
    endcase
`endif
    return W'(v);
  endfunction

  function automatic bit m_head_valid();
    logic [31:0] h;
    bit hz;
    if (mq.size() == 0) return 1'b0;
    h  = mq[0];
    hz = (m_u1(h) && h[19:15] != 5'd0 && pend[h[19:15]]) ||
         (m_u2(h) && h[24:20] != 5'd0 && pend[h[24:20]]);
    return !hz;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] h;
    bit ne;
    ne = (mq.size() != 0);
    h  = ne ? mq[0] : 32'h0;
    check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(m_head_valid()));
    check("rs1",     64'(rs1),     64'(h[19:15]));
    check("rs2",     64'(rs2),     64'(h[24:20]));
    check("rd",      64'(rd),      64'(h[11:7]));
    check("opcode",  64'(opcode),  64'(h[6:0]));
    check("func3",   64'(func3),   64'(h[14:12]));
    check("func7",   64'(func7),   64'(h[31:25]));
    check("f_en",    64'(f_en),    64'(h[28]));
    check("rd_we",   64'(rd_we),   64'(ne && m_we(h)));
    check("illegal", 64'(illegal), 64'(ne && !m_legal(h)));
    check("imm",     64'(imm),     64'(ne ? m_imm(h) : W'(0)));
  endtask

  // One clock: check outputs, drive inputs, advance the model, end at negedge
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit fl,
                       input bit ordy, input bit wbv, input logic [4:0] wbr);
    bit pop_m, push_m;
    logic [31:0] h;
    check_model();
    in_valid = iv; inst = ins; flush = fl; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbr;
    pop_m  = m_head_valid() && ordy;
    push_m = iv && (mq.size() < DEPTH) && !fl;
    h      = (mq.size() != 0) ? mq[0] : 32'h0;
    if (wbv) pend[wbr] = 1'b0;
    if (pop_m && m_we(h)) pend[h[11:7]] = 1'b1;
    if (fl) mq.delete();
    else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(ins);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic pulse_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd",        64'(rd),        64'd0);
    mq.delete();
    pend = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) r[6:0] = opl[k];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; pend = '0;
    #3;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_rd",        64'(rd),        64'd0);
    check("reset_imm",       64'(imm),       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5 then pop marks x1 pending
    cycle(1, 32'h00500093, 0, 1, 0, 5'd0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_rd",    64'(rd),        64'd1);
    check("addi_rs1",   64'(rs1),       64'd0);
    check("addi_we",    64'(rd_we),     64'd1);
`ifdef DECOD_PIPE_IMM_EN
    check("addi_imm",   64'(imm),       64'd5);
`else
    check("addi_imm",   64'(imm),       64'd0);
`endif
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    // add x2,x1,x1 waits for x1 writeback
    cycle(1, 32'h00108133, 0, 1, 0, 5'd0);
    check("add_stall0", 64'(out_valid), 64'd0);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    check("add_stall1", 64'(out_valid), 64'd0);
    cycle(0, 32'h0, 0, 1, 1, 5'd1);
    check("add_release", 64'(out_valid), 64'd1);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    cycle(0, 32'h0, 0, 0, 1, 5'd2);

    // Fill with out_ready low, extra word refused, one pop reopens
    cycle(1, 32'h000001B7, 0, 0, 0, 5'd0);
    cycle(1, 32'h00000237, 0, 0, 0, 5'd0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1, 32'h000002B7, 0, 0, 0, 5'd0);
    check("full_head_rd", 64'(rd), 64'd3);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    check("pop_in_ready", 64'(in_ready), 64'd1);
    check("pop_next_rd",  64'(rd),       64'd4);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    check("drained_rd",   64'(rd),       64'd0);
    cycle(0, 32'h0, 0, 0, 1, 5'd3);
    cycle(0, 32'h0, 0, 0, 1, 5'd4);

    // Illegal word and negative branch offset
    cycle(1, 32'hFFFFFFFF, 0, 0, 0, 5'd0);
    check("ill_flag",  64'(illegal),   64'd1);
    check("ill_we",    64'(rd_we),     64'd0);
    check("ill_imm",   64'(imm),       64'd0);
    check("ill_valid", 64'(out_valid), 64'd1);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    cycle(1, 32'hFE000EE3, 0, 0, 0, 5'd0);
`ifdef DECOD_PIPE_IMM_EN
    check("beq_imm", 64'(imm), 64'h00000000FFFFFFFC);
`else
    check("beq_imm", 64'(imm), 64'd0);
`endif
    cycle(0, 32'h0, 0, 1, 0, 5'd0);

    // Flush with a same-cycle push
    cycle(1, 32'h00000337, 0, 0, 0, 5'd0);
    cycle(1, 32'h000003B7, 0, 0, 0, 5'd0);
    cycle(1, 32'h00000437, 1, 0, 0, 5'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready),  64'd1);
    check("flush_rd",    64'(rd),        64'd0);

    // Reset mid-queue clears a pending hazard
    cycle(1, 32'h00000437, 0, 1, 0, 5'd0);
    cycle(0, 32'h0, 0, 1, 0, 5'd0);
    cycle(1, 32'h008404B3, 0, 0, 0, 5'd0);
    check("pre_rst_stall", 64'(out_valid), 64'd0);
    pulse_reset();
    cycle(1, 32'h008404B3, 0, 0, 0, 5'd0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    cycle(0, 32'h0, 1, 0, 0, 5'd0);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle(1'($urandom_range(0, 1)), rand_inst(), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)));
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
